reg_fifo_hs: RTL and testbench

//   Parametrised register-based synchronous FIFO with valid/ready handshake on both sides.

---
 rtl/reg_fifo_hs_if.sv | 30 +++
 rtl/reg_fifo_hs.sv | 95 +++++++++
 tb/tb_reg_fifo_hs.sv | 172 +++++++++++++++++
 3 files changed

// File: rtl/reg_fifo_hs_if.sv
// Handshake bundle for reg_fifo_hs: write side, read side, flush and occupancy status.
// slave is the FIFO's view, master is the view of the unit driving it.
interface reg_fifo_hs_if #(
   parameter int DATA_WIDTH = 32,
   parameter int FIFO_DEPTH = 4
);
   localparam int CNT_WIDTH = $clog2(FIFO_DEPTH + 1);

   logic                  i_flush;
   logic                  i_valid;
   logic                  o_ready;
   logic [DATA_WIDTH-1:0] i_data;
   logic                  o_valid;
   logic                  i_ready;
   logic [DATA_WIDTH-1:0] o_data;
   logic [CNT_WIDTH-1:0]  o_count;
   logic                  o_full;
   logic                  o_afull;
   logic                  o_empty;

   modport slave (
      input  i_flush, i_valid, i_data, i_ready,
      output o_ready, o_valid, o_data, o_count, o_full, o_afull, o_empty
   );

   modport master (
      output i_flush, i_valid, i_data, i_ready,
      input  o_ready, o_valid, o_data, o_count, o_full, o_afull, o_empty
   );
endinterface

// File: rtl/reg_fifo_hs.sv
// Register-based synchronous FIFO with valid/ready on both sides, flush and occupancy flags.
// Define REG_FIFO_BYPASS_EN for a zero-latency path from input to output while empty.
module reg_fifo_hs #(
   parameter int DATA_WIDTH  = 32,
   parameter int FIFO_DEPTH  = 4,
   parameter int AFULL_LEVEL = 3
) (
   input logic           i_clk,
   input logic           i_rst,
   reg_fifo_hs_if.slave  bus
);
   localparam int PTR_WIDTH = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
   localparam int CNT_WIDTH = $clog2(FIFO_DEPTH + 1);

   logic [DATA_WIDTH-1:0] mem_rd [FIFO_DEPTH];
   logic [PTR_WIDTH-1:0]  wr_ptr_reg, wr_ptr_next;
   logic [PTR_WIDTH-1:0]  rd_ptr_reg, rd_ptr_next;
   logic [CNT_WIDTH-1:0]  count_reg, count_next;
   logic                  full, empty, ready, valid, push, pop, wr_en;
   logic [DATA_WIDTH-1:0] head;

   assign full  = (count_reg == CNT_WIDTH'(FIFO_DEPTH));
   assign empty = (count_reg == '0);
   assign ready = ~full & ~i_rst;

`ifdef REG_FIFO_BYPASS_EN
   logic bypass;
   // While empty the incoming word is presented directly; if taken, both pointers step together.
   assign bypass = empty & ~bus.i_flush & ~i_rst;
   assign valid  = bypass ? bus.i_valid : (~empty & ~i_rst);
   assign head   = bypass ? bus.i_data  : mem_rd[rd_ptr_reg];
`else
   assign valid  = ~empty & ~i_rst;
   assign head   = mem_rd[rd_ptr_reg];
`endif

   assign push  = bus.i_valid & ready;
   assign pop   = valid & bus.i_ready;
   assign wr_en = push & ~bus.i_flush;

   generate
      for (genvar gi = 0; gi < FIFO_DEPTH; gi++) begin : g_entry
         logic [DATA_WIDTH-1:0] entry_reg;
         always_ff @(posedge i_clk) begin
            if (wr_en && (wr_ptr_reg == PTR_WIDTH'(gi))) begin
               entry_reg <= bus.i_data;
            end
         end
         assign mem_rd[gi] = entry_reg;
      end
   endgenerate

   always_comb begin
      wr_ptr_next = wr_ptr_reg;
      rd_ptr_next = rd_ptr_reg;
      count_next  = count_reg;
      if (bus.i_flush) begin
         wr_ptr_next = '0;
         rd_ptr_next = '0;
         count_next  = '0;
      end else begin
         if (push) begin
            wr_ptr_next = (wr_ptr_reg == PTR_WIDTH'(FIFO_DEPTH - 1)) ? '0 : wr_ptr_reg + PTR_WIDTH'(1);
         end
         if (pop) begin
            rd_ptr_next = (rd_ptr_reg == PTR_WIDTH'(FIFO_DEPTH - 1)) ? '0 : rd_ptr_reg + PTR_WIDTH'(1);
         end
         if (push && !pop) begin
            count_next = count_reg + CNT_WIDTH'(1);
         end else if (pop && !push) begin
            count_next = count_reg - CNT_WIDTH'(1);
         end
      end
   end

   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         wr_ptr_reg <= '0;
         rd_ptr_reg <= '0;
         count_reg  <= '0;
      end else begin
         wr_ptr_reg <= wr_ptr_next;
         rd_ptr_reg <= rd_ptr_next;
         count_reg  <= count_next;
      end
   end

   assign bus.o_ready = ready;
   assign bus.o_valid = valid;
   assign bus.o_data  = valid ? head : '0;
   assign bus.o_count = count_reg;
   assign bus.o_full  = full;
   assign bus.o_afull = (count_reg >= CNT_WIDTH'(AFULL_LEVEL));
   assign bus.o_empty = empty;
endmodule

// File: tb/tb_reg_fifo_hs.sv
// Scoreboard bench for reg_fifo_hs (DATA_WIDTH=8, FIFO_DEPTH=4, AFULL_LEVEL=3), either build.
// Stimulus queues expected words on acceptance; a negedge monitor pops and compares on each pop.
module tb_reg_fifo_hs;
`ifdef REG_FIFO_BYPASS_EN
   localparam bit BYP = 1'b1;
`else
   localparam bit BYP = 1'b0;
`endif
   localparam int DEPTH = 4;

   logic clk = 1'b0;
   logic rst = 1'b1;
   always #5 clk = ~clk;

   reg_fifo_hs_if #(.DATA_WIDTH(8), .FIFO_DEPTH(DEPTH)) bus ();

   reg_fifo_hs #(.DATA_WIDTH(8), .FIFO_DEPTH(DEPTH), .AFULL_LEVEL(3)) dut (
      .i_clk (clk),
      .i_rst (rst),
      .bus   (bus)
   );

   int         checks = 0;
   int         errors = 0;
   int         mcount = 0;
   logic       exp_valid = 1'b0;
   logic [7:0] exp_q[$];

   function automatic void chk(string name, logic [31:0] got, logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, got, exp, $time);
      end
   endfunction

   // One cycle: check registered status against the model, drive inputs, update the model.
   task automatic step(input logic v, input logic [7:0] d, input logic r, input logic f);
      logic acc, byp, pp;
      chk("count", 32'(bus.o_count), 32'(mcount));
      chk("empty", 32'(bus.o_empty), 32'(mcount == 0));
      chk("full",  32'(bus.o_full),  32'(mcount == DEPTH));
      chk("afull", 32'(bus.o_afull), 32'(mcount >= 3));
      chk("ready", 32'(bus.o_ready), 32'(mcount < DEPTH));
      bus.i_valid = v;
      bus.i_data  = d;
      bus.i_ready = r;
      bus.i_flush = f;
      acc = v && (mcount < DEPTH);
      byp = BYP && (mcount == 0) && !f;
      exp_valid = (mcount > 0) || (byp && v);
      pp  = r && exp_valid;
      if (f) begin
         exp_q.delete();
         mcount = 0;
      end else begin
         if (acc) exp_q.push_back(d);
         if (acc && !pp) mcount++;
         else if (!acc && pp) mcount--;
      end
      $display("step v=%0b d=%02h r=%0b f=%0b -> model count %0d", v, d, r, f, mcount);
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset(input int cycles);
      rst = 1'b1;
      bus.i_valid = 1'b1;
      bus.i_data  = 8'hAA;
      bus.i_ready = 1'b1;
      bus.i_flush = 1'b0;
      exp_valid = 1'b0;
      exp_q.delete();
      mcount = 0;
      for (int i = 0; i < cycles; i++) begin
         @(posedge clk);
         #1;
         chk("rst_count", 32'(bus.o_count), 32'd0);
         chk("rst_valid", 32'(bus.o_valid), 32'd0);
         chk("rst_data",  32'(bus.o_data),  32'd0);
         chk("rst_ready", 32'(bus.o_ready), 32'd0);
         chk("rst_empty", 32'(bus.o_empty), 32'd1);
         $display("reset cycle %0d", i);
      end
      bus.i_valid = 1'b0;
      bus.i_ready = 1'b0;
      rst = 1'b0;
      #0;
      chk("ready_after_rst", 32'(bus.o_ready), 32'd1);
   endtask

   // Monitor: compare valid and popped data at the inactive edge.
   always @(negedge clk) begin
      if (!rst && !bus.i_flush) begin
         chk("o_valid", 32'(bus.o_valid), 32'(exp_valid));
         if (!bus.o_valid) begin
            chk("data_zero", 32'(bus.o_data), 32'd0);
         end else if (bus.i_ready) begin
            if (exp_q.size() == 0) begin
               checks++;
               errors++;
               $display("FAIL pop_underflow: got %02h expected no pop", bus.o_data);
            end else begin
               logic [7:0] e;
               e = exp_q.pop_front();
               chk("pop_data", 32'(bus.o_data), 32'(e));
               $display("pop data=%02h expected=%02h", bus.o_data, e);
            end
         end
      end
   end

   initial begin
      bus.i_valid = 1'b0;
      bus.i_data  = 8'h00;
      bus.i_ready = 1'b0;
      bus.i_flush = 1'b0;

      // 1. reset with active input
      do_reset(2);

      // 2. fill, overfill, drain
      step(1, 8'h11, 0, 0);
      step(1, 8'h22, 0, 0);
      step(1, 8'h33, 0, 0);
      step(1, 8'h44, 0, 0);
      step(1, 8'h55, 0, 0);
      for (int i = 0; i < 4; i++) step(0, 8'h00, 1, 0);
      step(0, 8'h00, 0, 0);

      // 3. steady count 2 with simultaneous push/pop across wrap
      step(1, 8'h60, 0, 0);
      step(1, 8'h61, 0, 0);
      for (int i = 0; i < 10; i++) step(1, 8'(8'h62 + i), 1, 0);
      step(0, 8'h00, 1, 0);
      step(0, 8'h00, 1, 0);
      step(0, 8'h00, 0, 0);

      // 4. full plus pop: no push-through, accepted next cycle
      step(1, 8'hA0, 0, 0);
      step(1, 8'hA1, 0, 0);
      step(1, 8'hA2, 0, 0);
      step(1, 8'hA3, 0, 0);
      step(1, 8'h77, 1, 0);
      step(1, 8'h77, 0, 0);

      // 5. flush at count 3 with push and pop requested
      step(0, 8'h00, 1, 0);
      step(1, 8'h99, 1, 1);
      step(0, 8'h00, 1, 0);
      step(1, 8'hC3, 0, 0);
      step(0, 8'h00, 1, 0);
      step(0, 8'h00, 0, 0);

      // 6. empty with valid and ready (bypass or one-cycle latency)
      step(1, 8'h5A, 1, 0);
      step(0, 8'h00, 1, 0);
      step(0, 8'h00, 0, 0);

      // reset in the middle of traffic drops everything
      step(1, 8'hD0, 0, 0);
      step(1, 8'hD1, 0, 0);
      do_reset(1);
      step(1, 8'hE0, 0, 0);
      step(0, 8'h00, 1, 0);
      step(0, 8'h00, 0, 0);

      chk("queue_drained", 32'(exp_q.size()), 32'd0);
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
